// File: rtl/apb_slave_pkg.sv
// Shared constants and types for the APB register slave: register byte
// offsets, the transfer FSM state encoding and the wait-state ceiling.
package apb_slave_pkg;

    localparam logic [31:0] CTRL_OFS     = 32'h00;
    localparam logic [31:0] SCRATCH_OFS  = 32'h04;
    localparam logic [31:0] STATUS_OFS   = 32'h08;
    localparam logic [31:0] IRQ_PEND_OFS = 32'h0C;
    localparam logic [31:0] IRQ_MASK_OFS = 32'h10;
    localparam logic [31:0] LAST_OFS     = 32'h10;

    // Largest wait-state count the 4-bit counter can hold
    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

endpackage

// File: rtl/apb_irq_ctrl.sv
// Interrupt pending/mask registers. Pending bits are set by event pulses and
// cleared by write-1-to-clear; a set in the same cycle as a clear wins.
// irq is registered from the next-state pending and mask values so it
// always tracks the registers it is derived from.
module apb_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NUM_IRQ-1:0] evt,
    input  logic               pend_we,
    input  logic               mask_we,
    input  logic [31:0]        wdata,
    input  logic [31:0]        wbe,
    output logic [31:0]        pend,
    output logic [31:0]        mask,
    output logic               irq
);

    // Only the low NUM_IRQ bits exist; everything above reads back as 0
    localparam logic [31:0] VALID = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << NUM_IRQ) - 32'd1);

    logic [31:0] evt_w;
    logic [31:0] pend_nxt;
    logic [31:0] mask_nxt;

    // Next-state: clear first, then OR in new events so set has priority
    always_comb begin
        evt_w                = '0;
        evt_w[NUM_IRQ-1:0]   = evt;
        pend_nxt             = pend;
        if (pend_we)
            pend_nxt = pend & ~(wdata & wbe);
        pend_nxt = (pend_nxt | evt_w) & VALID;
        mask_nxt = mask;
        if (mask_we)
            mask_nxt = ((mask & ~wbe) | (wdata & wbe)) & VALID;
    end

    // Register pending, mask and the combined interrupt level
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pend <= '0;
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            mask <= mask_nxt;
            irq  <= |(pend_nxt & mask_nxt);
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a small register file (CTRL, SCRATCH, STATUS,
// IRQ_PEND, IRQ_MASK), programmable wait states and error response.
// Optional build macro APB_PSTRB_EN adds a pstrb byte-lane write strobe.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] CTRL_RST    = 32'h0000_0000,
    parameter int          NUM_IRQ     = 8
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [31:0]        pwdata,
`ifdef APB_PSTRB_EN
    input  logic [3:0]         pstrb,
`endif
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic [31:0]        ctrl_o,
    input  logic [31:0]        status_i,
    input  logic [NUM_IRQ-1:0] irq_evt_i,
    output logic               irq_o
);

    localparam int CNT_INIT = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                write_q;
    logic [31:0]         ctrl;
    logic [31:0]         scratch;
    logic [31:0]         pend;
    logic [31:0]         mask;
    logic [31:0]         dec_addr;
    logic                dec_write;
    logic                dec_err;
    logic [31:0]         dec_data;
    logic [31:0]         wbe;
    logic                commit;

`ifdef APB_PSTRB_EN
    logic [3:0]          strb_q;

    // Expand captured byte strobes into a per-bit write enable
    always_comb begin
        for (int b = 0; b < 4; b++)
            wbe[8*b +: 8] = {8{strb_q[b]}};
    end
`else
    assign wbe = '1;
`endif

    // Decode the live bus in IDLE (zero-wait entry) and the captured
    // transfer otherwise; read data and error are produced here
    always_comb begin
        dec_addr             = '0;
        dec_addr[ADDR_W-1:0] = (state == IDLE) ? paddr : addr_q;
        dec_write            = (state == IDLE) ? pwrite : write_q;
        dec_err              = (dec_addr[1:0] != 2'b00) || (dec_addr > LAST_OFS) ||
                               (dec_write && (dec_addr == STATUS_OFS));
        dec_data             = '0;
        if (!dec_err && !dec_write) begin
            case (dec_addr)
                CTRL_OFS:     dec_data = ctrl;
                SCRATCH_OFS:  dec_data = scratch;
                STATUS_OFS:   dec_data = status_i;
                IRQ_PEND_OFS: dec_data = pend;
                IRQ_MASK_OFS: dec_data = mask;
                default:      dec_data = '0;
            endcase
        end
    end

    // A write lands only on the completing edge of a legal transfer
    assign commit = (state == READY) && psel && penable && write_q && !dec_err;

    // Transfer FSM with registered pready/prdata/pslverr
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
`ifdef APB_PSTRB_EN
            strb_q  <= '0;
`endif
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (psel && !penable) begin
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                        write_q <= pwrite;
`ifdef APB_PSTRB_EN
                        strb_q  <= pstrb;
`endif
                        cnt     <= 4'(CNT_INIT);
                        if (CNT_INIT == 0) begin
                            state   <= READY;
                            pready  <= 1'b1;
                            prdata  <= dec_data;
                            pslverr <= dec_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        if (cnt == 4'd1) begin
                            state   <= READY;
                            pready  <= 1'b1;
                            prdata  <= dec_data;
                            pslverr <= dec_err;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

    // CTRL and SCRATCH storage, byte-lane aware
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl    <= CTRL_RST;
            scratch <= '0;
        end else begin
            if (commit && dec_addr == CTRL_OFS)
                ctrl <= (ctrl & ~wbe) | (wdata_q & wbe);
            if (commit && dec_addr == SCRATCH_OFS)
                scratch <= (scratch & ~wbe) | (wdata_q & wbe);
        end
    end

    assign ctrl_o = ctrl;

    apb_irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq (
        .pclk    (pclk),
        .presetn (presetn),
        .evt     (irq_evt_i),
        .pend_we (commit && dec_addr == IRQ_PEND_OFS),
        .mask_we (commit && dec_addr == IRQ_MASK_OFS),
        .wdata   (wdata_q),
        .wbe     (wbe),
        .pend    (pend),
        .mask    (mask),
        .irq     (irq_o)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: two instances (zero and three wait states)
// driven by per-scenario tasks; expected responses are queued when a
// transfer is launched and compared when pready is observed.
module tb_apb_reg_slave;

    logic             pclk = 1'b0;
    logic             presetn = 1'b0;
    logic [1:0]       psel = '0;
    logic [1:0]       penable = '0;
    logic [1:0]       pwrite = '0;
    logic [1:0][11:0] paddr = '0;
    logic [1:0][31:0] pwdata = '0;
    logic [1:0][31:0] prdata;
    logic [1:0]       pready;
    logic [1:0]       pslverr;
    logic [1:0][31:0] ctrl;
    logic [1:0][31:0] status = '0;
    logic [1:0][7:0]  evt = '0;
    logic [1:0]       irq;
`ifdef APB_PSTRB_EN
    logic [1:0][3:0]  pstrb = '1;
    logic [3:0]       cur_strb = 4'hF;
`endif

    typedef struct {
        bit          chk;
        logic [31:0] rd;
        bit          err;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [31:0] RST1 = 32'hA5A5_0000;

    always #5 pclk = ~pclk;

    apb_reg_slave #(.ADDR_W(12), .WAIT_CYCLES(0), .CTRL_RST(32'h0), .NUM_IRQ(8)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb[0]),
`endif
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
        .ctrl_o(ctrl[0]), .status_i(status[0]), .irq_evt_i(evt[0]), .irq_o(irq[0]));

    apb_reg_slave #(.ADDR_W(12), .WAIT_CYCLES(3), .CTRL_RST(RST1), .NUM_IRQ(8)) dut3 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb[1]),
`endif
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
        .ctrl_o(ctrl[1]), .status_i(status[1]), .irq_evt_i(evt[1]), .irq_o(irq[1]));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One full transfer; evt_c is pulsed on the completing edge.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input bit chk, input logic [31:0] erd,
                        input bit eerr, input logic [7:0] evt_c);
        exp_t e;
        int   w;
        sb.push_back('{chk: chk, rd: erd, err: eerr, waits: (d == 0) ? 0 : 3});
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
`ifdef APB_PSTRB_EN
        pstrb[d] = cur_strb;
`endif
        step(1);
        penable[d] = 1'b1;
        w = 0;
        while (!pready[d] && w < 40) begin
            step(1);
            w++;
        end
        e = sb.pop_front();
        checks++;
        if (!pready[d]) begin
            errors++;
            $display("FAIL timeout dut%0d addr=%h: pready never rose", d, a);
        end else begin
            if (w !== e.waits) begin
                errors++;
                $display("FAIL waits dut%0d addr=%h: got %0d want %0d", d, a, w, e.waits);
            end
            checks++;
            if (pslverr[d] !== e.err) begin
                errors++;
                $display("FAIL pslverr dut%0d addr=%h: got %b want %b", d, a, pslverr[d], e.err);
            end
            if (e.chk) begin
                checks++;
                if (prdata[d] !== e.rd) begin
                    errors++;
                    $display("FAIL prdata dut%0d addr=%h: got %h want %h", d, a, prdata[d], e.rd);
                end
            end
        end
        evt[d] = evt_c;
        step(1);
        evt[d] = '0;
        psel[d] = 1'b0; penable[d] = 1'b0;
        checks++;
        if (pready[d] !== 1'b0) begin
            errors++;
            $display("FAIL pready_drop dut%0d: got %b want 0", d, pready[d]);
        end
    endtask

    task automatic wr(input int d, input logic [11:0] a, input logic [31:0] v, input bit eerr);
        xfer(d, 1'b1, a, v, 1'b0, 32'h0, eerr, 8'h0);
    endtask

    task automatic rd(input int d, input logic [11:0] a, input logic [31:0] v, input bit eerr);
        xfer(d, 1'b0, a, 32'h0, 1'b1, v, eerr, 8'h0);
    endtask

    task automatic chk_ctrl(input int d, input logic [31:0] v, input string nm);
        checks++;
        if (ctrl[d] !== v) begin
            errors++;
            $display("FAIL %s dut%0d ctrl_o: got %h want %h", nm, d, ctrl[d], v);
        end
    endtask

    task automatic chk_irq(input int d, input logic v, input string nm);
        checks++;
        if (irq[d] !== v) begin
            errors++;
            $display("FAIL %s dut%0d irq_o: got %b want %b", nm, d, irq[d], v);
        end
    endtask

    task automatic test_reset();
        step(3);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({prdata[d], pready[d], pslverr[d]} !== 34'h0) begin
                errors++;
                $display("FAIL reset_bus dut%0d: got %h/%b/%b want 0/0/0", d, prdata[d], pready[d], pslverr[d]);
            end
            chk_irq(d, 1'b0, "reset_irq");
        end
        chk_ctrl(0, 32'h0, "reset_ctrl");
        chk_ctrl(1, RST1, "reset_ctrl");
        presetn = 1'b1;
        step(2);
        rd(0, 12'h004, 32'h0, 1'b0);
        rd(0, 12'h00C, 32'h0, 1'b0);
        rd(0, 12'h010, 32'h0, 1'b0);
    endtask

    task automatic test_rw_zero_wait();
        wr(0, 12'h004, 32'hDEAD_BEEF, 1'b0);
        rd(0, 12'h004, 32'hDEAD_BEEF, 1'b0);
        wr(0, 12'h000, 32'h1111_2222, 1'b0);
        chk_ctrl(0, 32'h1111_2222, "ctrl_write");
        rd(0, 12'h000, 32'h1111_2222, 1'b0);
    endtask

    task automatic test_status_wait();
        status[1] = 32'h1234_5678;
        rd(1, 12'h008, 32'h1234_5678, 1'b0);
        status[1] = 32'h0BAD_CAFE;
        rd(1, 12'h008, 32'h0BAD_CAFE, 1'b0);
    endtask

    task automatic test_errors();
        wr(0, 12'h008, 32'hFFFF_FFFF, 1'b1);
        wr(0, 12'h014, 32'hFFFF_FFFF, 1'b1);
        wr(0, 12'h006, 32'hFFFF_FFFF, 1'b1);
        wr(0, 12'h001, 32'hFFFF_FFFF, 1'b1);
        rd(0, 12'h002, 32'h0, 1'b1);
        rd(0, 12'h014, 32'h0, 1'b1);
        chk_ctrl(0, 32'h1111_2222, "err_ctrl");
        rd(0, 12'h004, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_irq();
        wr(0, 12'h010, 32'hFFFF_FFFF, 1'b0);
        rd(0, 12'h010, 32'h0000_00FF, 1'b0);
        wr(0, 12'h010, 32'h0000_0001, 1'b0);
        chk_irq(0, 1'b0, "irq_idle");
        evt[0] = 8'h01;
        step(1);
        evt[0] = 8'h00;
        chk_irq(0, 1'b1, "irq_set");
        rd(0, 12'h00C, 32'h0000_0001, 1'b0);
        // W1C coincident with a fresh event on the same bit
        xfer(0, 1'b1, 12'h00C, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 8'h01);
        chk_irq(0, 1'b1, "irq_set_wins");
        rd(0, 12'h00C, 32'h0000_0001, 1'b0);
        wr(0, 12'h00C, 32'h0000_0001, 1'b0);
        chk_irq(0, 1'b0, "irq_cleared");
        rd(0, 12'h00C, 32'h0, 1'b0);
        // Masked source sets pending without raising irq
        evt[0] = 8'h08;
        step(1);
        evt[0] = 8'h00;
        chk_irq(0, 1'b0, "irq_masked");
        rd(0, 12'h00C, 32'h0000_0008, 1'b0);
        wr(0, 12'h00C, 32'hFFFF_FFFF, 1'b0);
        rd(0, 12'h00C, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        wr(1, 12'h004, 32'hCAFE_0001, 1'b0);
        wr(1, 12'h000, 32'h0F0F_0F0F, 1'b0);
        rd(1, 12'h004, 32'hCAFE_0001, 1'b0);
        rd(1, 12'h000, 32'h0F0F_0F0F, 1'b0);
        chk_ctrl(1, 32'h0F0F_0F0F, "b2b_ctrl");
        wr(0, 12'h004, 32'h1357_9BDF, 1'b0);
        rd(0, 12'h004, 32'h1357_9BDF, 1'b0);
    endtask

    task automatic test_protocol();
        // psel dropped during WAIT
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h000; pwdata[1] = 32'h0000_0077;
        step(1);
        penable[1] = 1'b1;
        step(1);
        psel[1] = 1'b0; penable[1] = 1'b0;
        step(4);
        checks++;
        if (pready[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait pready: got %b want 0", pready[1]);
        end
        chk_ctrl(1, 32'h0F0F_0F0F, "abort_wait");
        // psel dropped while READY
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h000; pwdata[0] = 32'h0000_0099;
        step(1);
        psel[0] = 1'b0;
        step(1);
        checks++;
        if (pready[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready pready: got %b want 0", pready[0]);
        end
        chk_ctrl(0, 32'h1111_2222, "abort_ready");
        rd(1, 12'h000, 32'h0F0F_0F0F, 1'b0);
        rd(0, 12'h000, 32'h1111_2222, 1'b0);
    endtask

    task automatic test_reset_mid();
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h000; pwdata[1] = 32'h5555_5555;
        step(1);
        penable[1] = 1'b1;
        step(1);
        presetn = 1'b0;
        #1;
        chk_ctrl(1, RST1, "midreset");
        checks++;
        if (pready[1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset pready: got %b want 0", pready[1]);
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        step(2);
        presetn = 1'b1;
        step(2);
        chk_ctrl(1, RST1, "postreset");
        wr(1, 12'h000, 32'h0BAD_F00D, 1'b0);
        chk_ctrl(1, 32'h0BAD_F00D, "fresh_write");
        rd(1, 12'h004, 32'h0, 1'b0);
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_pstrb();
        cur_strb = 4'hF;
        wr(0, 12'h004, 32'hFFFF_FFFF, 1'b0);
        cur_strb = 4'b0101;
        wr(0, 12'h004, 32'h0000_0000, 1'b0);
        cur_strb = 4'h0;
        wr(0, 12'h004, 32'h1234_5678, 1'b0);
        cur_strb = 4'hF;
        rd(0, 12'h004, 32'hFF00_FF00, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_rw_zero_wait();
        test_status_wait();
        test_errors();
        test_irq();
        test_back_to_back();
        test_protocol();
`ifdef APB_PSTRB_EN
        test_pstrb();
`endif
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
